// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage: holds the PC, reads one 32-bit instruction per
//   fetch over a req/ack handshake, strobes the decoder for one cycle, then
//   waits for the execution stage before computing the next PC
//   (sequential, branch or jump; PC-relative, modulo 2^32).
//   Optional feature macro: FETCH_TIMEOUT_EN (adds a REQ watchdog and the
//   sticky o_fetch_fault output).
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic        o_dec_en,
  output logic [31:0] o_pc,
  input  logic        i_exec_done,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_offset,
  input  logic        i_jump_taken,
  input  logic [31:0] i_jump_offset,
  input  logic        i_halt,
  output logic        o_halted,
  output logic        o_misalign,
`ifdef FETCH_TIMEOUT_EN
  output logic        o_fetch_fault,
`endif
  output logic [31:0] o_inst_count
);

  localparam logic [31:0] C_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_STROBE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_imem_req;
  logic        r_dec_en;
  logic        r_halted;
  logic        r_misalign;
  logic [31:0] r_inst_count;
  logic [31:0] w_target;

`ifdef FETCH_TIMEOUT_EN
  localparam int C_TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Last unacknowledged REQ cycle before the watchdog fires.
  localparam logic [C_TW-1:0] C_TO_LAST = C_TW'(TIMEOUT_CYCLES - 1);
  logic [C_TW-1:0] r_to_cnt;
  logic            r_fetch_fault;
  assign o_fetch_fault = r_fetch_fault;
`else
  // Without the watchdog the timeout parameter has no effect.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_inert
  end
`endif

  // Next-PC target: jump beats branch beats sequential; 32-bit wraparound.
  always_comb begin
    w_target = r_pc + 32'd4;
    if (i_jump_taken) begin
      w_target = r_pc + i_jump_offset;
    end else if (i_branch_taken) begin
      w_target = r_pc + i_branch_offset;
    end
  end

  // Fetch state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_imem_req   <= 1'b0;
      r_dec_en     <= 1'b0;
      r_halted     <= 1'b0;
      r_misalign   <= 1'b0;
      r_inst_count <= '0;
`ifdef FETCH_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_fetch_fault <= 1'b0;
`endif
    end else begin
      r_dec_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (i_imem_ack) begin
            r_inst       <= i_imem_rdata;
            r_imem_req   <= 1'b0;
            r_dec_en     <= 1'b1;
            r_inst_count <= r_inst_count + 32'd1;
            r_state      <= S_STROBE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_to_cnt == C_TO_LAST) begin
            // Memory never answered: give up and park the stage.
            r_fetch_fault <= 1'b1;
            r_halted      <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= S_HALTED;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        S_STROBE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (i_exec_done) begin
            if (i_halt || (r_inst == C_EBREAK)) begin
              r_halted <= 1'b1;
              r_state  <= S_HALTED;
            end else if (w_target[1:0] != 2'b00) begin
              // Unaligned target: keep the faulting PC visible.
              r_misalign <= 1'b1;
              r_halted   <= 1'b1;
              r_state    <= S_HALTED;
            end else begin
              r_pc       <= w_target;
              r_imem_req <= 1'b1;
              r_state    <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
              r_to_cnt   <= '0;
`endif
            end
          end
        end
        S_HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req   = r_imem_req;
  assign o_imem_addr  = r_pc;
  assign o_inst       = r_inst;
  assign o_dec_en     = r_dec_en;
  assign o_pc         = r_pc;
  assign o_halted     = r_halted;
  assign o_misalign   = r_misalign;
  assign o_inst_count = r_inst_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
//   Directed plus randomized bench for inst_fetch. A reference model keeps the
//   architectural PC, latched instruction, strobe count and halt/misalign
//   flags, advanced from the next-PC rules with plain arithmetic.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] NOP_OP   = 32'h0000_0033;
`ifdef FETCH_TIMEOUT_EN
  localparam int WS = 3;
`else
  localparam int WS = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [31:0] o_inst;
  logic        o_dec_en;
  logic [31:0] o_pc;
  logic        i_exec_done = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_offset = '0;
  logic        i_jump_taken = 1'b0;
  logic [31:0] i_jump_offset = '0;
  logic        i_halt = 1'b0;
  logic        o_halted;
  logic        o_misalign;
  logic [31:0] o_inst_count;
`ifdef FETCH_TIMEOUT_EN
  logic        o_fetch_fault;
`endif

  inst_fetch #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_inst          (o_inst),
    .o_dec_en        (o_dec_en),
    .o_pc            (o_pc),
    .i_exec_done     (i_exec_done),
    .i_branch_taken  (i_branch_taken),
    .i_branch_offset (i_branch_offset),
    .i_jump_taken    (i_jump_taken),
    .i_jump_offset   (i_jump_offset),
    .i_halt          (i_halt),
    .o_halted        (o_halted),
    .o_misalign      (o_misalign),
`ifdef FETCH_TIMEOUT_EN
    .o_fetch_fault   (o_fetch_fault),
`endif
    .o_inst_count    (o_inst_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_count;
  logic        m_halted;
  logic        m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exec_inputs();
    i_exec_done     = 1'b0;
    i_branch_taken  = 1'b0;
    i_branch_offset = '0;
    i_jump_taken    = 1'b0;
    i_jump_offset   = '0;
    i_halt          = 1'b0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = $urandom;
    clear_exec_inputs();
    step();
    step();
    rst_n    = 1'b1;
    m_pc     = RESET_PC;
    m_inst   = '0;
    m_count  = '0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
    chk1("rst_req", o_imem_req, 1'b0);
    chk ("rst_addr", o_imem_addr, RESET_PC);
    chk ("rst_pc", o_pc, RESET_PC);
    chk ("rst_inst", o_inst, 32'h0);
    chk1("rst_dec_en", o_dec_en, 1'b0);
    chk1("rst_halted", o_halted, 1'b0);
    chk1("rst_misalign", o_misalign, 1'b0);
    chk ("rst_count", o_inst_count, 32'h0);
  endtask

  task automatic do_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk1("start_req", o_imem_req, 1'b1);
    chk ("start_addr", o_imem_addr, m_pc);
  endtask

  // Serve one fetch from the REQ state after 'waits' unacknowledged cycles.
  task automatic fetch(input int waits, input logic [31:0] word);
    for (int k = 0; k <= waits; k++) begin
      chk1("req_hold", o_imem_req, 1'b1);
      chk ("addr_hold", o_imem_addr, m_pc);
      if (k < waits) begin
        chk("inst_hold", o_inst, m_inst);
        step();
      end
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = word;
    step();
    i_imem_ack   = 1'b0;
    i_imem_rdata = $urandom;
    m_inst  = word;
    m_count = m_count + 32'd1;
    chk1("strobe_dec_en", o_dec_en, 1'b1);
    chk ("strobe_inst", o_inst, m_inst);
    chk ("strobe_count", o_inst_count, m_count);
    chk1("strobe_req_low", o_imem_req, 1'b0);
    chk ("strobe_pc", o_pc, m_pc);
    step();
    chk1("exec_dec_en_low", o_dec_en, 1'b0);
  endtask

  // Complete the current instruction after 'dly' idle EXEC cycles.
  task automatic exec(input int dly, input logic br, input logic [31:0] boff,
                      input logic jp, input logic [31:0] joff, input logic hl);
    logic [31:0] tgt;
    for (int k = 0; k < dly; k++) begin
      chk1("exec_wait_dec_en", o_dec_en, 1'b0);
      chk1("exec_wait_req", o_imem_req, 1'b0);
      step();
    end
    i_exec_done     = 1'b1;
    i_branch_taken  = br;
    i_branch_offset = boff;
    i_jump_taken    = jp;
    i_jump_offset   = joff;
    i_halt          = hl;
    step();
    clear_exec_inputs();
    if (hl || m_inst == EBREAK) begin
      m_halted = 1'b1;
    end else begin
      if (jp)      tgt = m_pc + joff;
      else if (br) tgt = m_pc + boff;
      else         tgt = m_pc + 32'd4;
      if ((tgt % 4) != 0) begin
        m_mis    = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end
    chk1("next_halted", o_halted, m_halted);
    chk1("next_misalign", o_misalign, m_mis);
    chk ("next_pc", o_pc, m_pc);
    chk1("next_req", o_imem_req, !m_halted);
    if (!m_halted) chk("next_addr", o_imem_addr, m_pc);
  endtask

  task automatic halted_ignores_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1("halt_req_low", o_imem_req, 1'b0);
      chk1("halt_flag", o_halted, 1'b1);
      chk1("halt_dec_en", o_dec_en, 1'b0);
      step();
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == EBREAK) w = NOP_OP;
    return w;
  endfunction

  function automatic logic [31:0] rand_off();
    int o;
    o = (int'($urandom_range(0, 63)) - 32) * 4;
    return 32'(o);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // IDLE ignores ack and exec_done
    i_imem_ack  = 1'b1;
    i_exec_done = 1'b1;
    step();
    i_imem_ack  = 1'b0;
    i_exec_done = 1'b0;
    chk1("idle_ignore_req", o_imem_req, 1'b0);
    chk ("idle_ignore_count", o_inst_count, 32'h0);

    // Sequential fetch at 0, 4, 8
    do_start();
    for (int n = 0; n < 3; n++) begin
      chk("seq_addr", o_imem_addr, 32'(n * 4));
      fetch(0, NOP_OP);
      exec(1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    end
    chk("seq_count", o_inst_count, 32'd3);

    // Reach 0x10, then branch back by 8
    fetch(0, NOP_OP);
    exec(1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("at_0x10", o_imem_addr, 32'h10);
    fetch(0, NOP_OP);
    exec(0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0);
    chk("branch_target", o_imem_addr, 32'h08);
    fetch(0, NOP_OP);
    exec(0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    // Both taken at 0x10: jump wins
    fetch(0, NOP_OP);
    exec(0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h20, 1'b0);
    chk("jump_wins", o_imem_addr, 32'h30);

    // Wait states; a stray exec_done in REQ is ignored
    i_exec_done  = 1'b1;
    i_jump_taken = 1'b1;
    i_jump_offset = 32'h100;
    step();
    clear_exec_inputs();
    chk("stray_exec_addr", o_imem_addr, 32'h30);
    fetch(WS - 1, 32'hDEAD_BEE0);

    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic with aligned offsets
    for (int n = 0; n < 25; n++) begin
      fetch(int'($urandom_range(0, 3)), rand_word());
      exec(int'($urandom_range(0, 3)), 1'($urandom), rand_off(), 1'($urandom), rand_off(), 1'b0);
    end

    // Wrap from 0xFFFF_FFFC to 0
    fetch(0, NOP_OP);
    exec(0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC - m_pc, 1'b0);
    chk("wrap_pre", o_imem_addr, 32'hFFFF_FFFC);
    fetch(1, NOP_OP);
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap_zero", o_imem_addr, 32'h0);

    // Misaligned jump halts with pc unchanged
    fetch(0, NOP_OP);
    exec(0, 1'b0, 32'h0, 1'b1, 32'h2, 1'b0);
    chk1("misalign_set", o_misalign, 1'b1);
    chk ("misalign_pc", o_pc, 32'h0);
    halted_ignores_start();

    // EBREAK halts
    do_reset();
    do_start();
    fetch(0, EBREAK);
    exec(2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk1("ebreak_halted", o_halted, 1'b1);
    halted_ignores_start();

    // halt input overrides a jump
    do_reset();
    do_start();
    fetch(1, NOP_OP);
    exec(0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
    chk("halt_pc", o_pc, RESET_PC);
    halted_ignores_start();

    // Asynchronous reset while in REQ
    do_reset();
    do_start();
    fetch(0, NOP_OP);
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk1("pre_areset_req", o_imem_req, 1'b1);
    rst_n = 1'b0;
    #2;
    chk1("areset_req", o_imem_req, 1'b0);
    chk ("areset_pc", o_pc, RESET_PC);
    chk ("areset_addr", o_imem_addr, RESET_PC);
    chk ("areset_inst", o_inst, 32'h0);
    chk ("areset_count", o_inst_count, 32'h0);
    #2;
    rst_n    = 1'b1;
    m_pc     = RESET_PC;
    m_inst   = '0;
    m_count  = '0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
    step();
    chk1("post_areset_idle", o_imem_req, 1'b0);
    do_start();
    fetch(0, NOP_OP);

`ifdef FETCH_TIMEOUT_EN
    // Ack in the last allowed cycle wins, then a silent memory faults
    do_reset();
    do_start();
    fetch(3, NOP_OP);
    chk1("late_ack_no_fault", o_fetch_fault, 1'b0);
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk1("to_req_wait", o_imem_req, 1'b1);
      chk1("to_no_fault_yet", o_fetch_fault, 1'b0);
      step();
    end
    chk1("to_req_cycle4", o_imem_req, 1'b1);
    step();
    chk1("to_fault", o_fetch_fault, 1'b1);
    chk1("to_halted", o_halted, 1'b1);
    chk1("to_req_low", o_imem_req, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
